// File: rtl/spi_mmc_pkg.sv
// Shared types and constants for the SPI MMC master: request opcodes, FSM states
// and the number of trailing clocks issued after a deselect.
package spi_mmc_pkg;

  typedef enum logic [1:0] {
    OP_XFER     = 2'd0,
    OP_DESELECT = 2'd1,
    OP_INIT     = 2'd2,
    OP_SETDIV   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    WRITE    = 3'd2,
    READ     = 3'd3,
    DESELECT = 3'd4,
    SETDIV   = 3'd5,
    DONE     = 3'd6
  } state_e;

  localparam int DESELECT_CLOCKS = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_mmc_master_spi_clk_tick.sv
// SCLK half-period timer: counts 0..div while enabled and pulses tick on the
// last count, so one half-period lasts div+1 clk cycles.
module spi_clk_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] clkcnt_q;
  logic [DIV_W-1:0] clkcnt_d;

  assign tick = en && (clkcnt_q == div);

  always_comb begin
    if (!en || tick) begin
      clkcnt_d = '0;
    end else begin
      clkcnt_d = clkcnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clkcnt_q <= '0;
    end else begin
      clkcnt_q <= clkcnt_d;
    end
  end

endmodule

// File: rtl/spi_mmc_master.sv
// SPI master for SD/MMC cards: init clocking, write-then-read transfers, deselect
// with trailing clocks and a runtime-programmable SCLK divider.
module spi_mmc_master
  import spi_mmc_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_CS      = 2,
  parameter int DIV_W       = 8,
  parameter int DIV_RESET   = 100,
  parameter int INIT_CLOCKS = 80,
  parameter bit CPOL        = 1'b1,
  localparam int BITS_W     = $clog2(DATA_W + 1),
  localparam int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BITS_W-1:0] wr_bits,
  input  logic [BITS_W-1:0] rd_bits,
  input  logic [CS_W-1:0]   cs_sel,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic [DIV_W-1:0]  div_q,
  output logic [NUM_CS-1:0] spi_csn,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int CNT_W = $clog2(max3(DATA_W, INIT_CLOCKS, DESELECT_CLOCKS) + 1);

  state_e            state_q, state_d;
  logic              phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BITS_W-1:0] rd_len_q, rd_len_d;
  logic [NUM_CS-1:0] csn_q, csn_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DIV_W-1:0]  div_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic              clk_en_s;
  logic              tick_s;
  logic [DATA_W-1:0] shift_s;
  logic [DATA_W-1:0] mask_s;
  logic [BITS_W-1:0] wr_len_s;
  logic [BITS_W-1:0] rd_len_s;

  // Zero-length phases never enable the timer, so the next phase starts on a full half-period.
  assign clk_en_s = (state_q inside {INIT, WRITE, READ, DESELECT}) && (cnt_q != '0);

  spi_clk_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (clk_en_s),
    .div   (div_q),
    .tick  (tick_s)
  );

  assign shift_s  = {shreg_q[DATA_W-2:0], spi_miso};
  assign wr_len_s = (int'(wr_bits) > DATA_W) ? BITS_W'(DATA_W) : wr_bits;
  assign rd_len_s = (int'(rd_bits) > DATA_W) ? BITS_W'(DATA_W) : rd_bits;

  always_comb begin
    for (int i = 0; i < DATA_W; i++) begin
      mask_s[i] = (i < int'(rd_len_q));
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    rd_len_d = rd_len_q;
    csn_d    = csn_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    rdata_d  = rdata_q;
    div_d    = div_q;
    busy_d   = busy_q;
    ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          busy_d   = 1'b1;
          phase_d  = 1'b0;
          shreg_d  = '1;
          rd_len_d = rd_len_s;
          case (op_e'(op))
            OP_XFER: begin
              if (32'(cs_sel) < NUM_CS) begin
                state_d = WRITE;
                shreg_d = wdata;
                csn_d   = ~(NUM_CS'(1) << cs_sel);
                cnt_d   = CNT_W'(wr_len_s);
              end else begin
                state_d = DESELECT;
                csn_d   = '1;
                cnt_d   = CNT_W'(DESELECT_CLOCKS);
              end
            end
            OP_DESELECT: begin
              state_d = DESELECT;
              csn_d   = '1;
              cnt_d   = CNT_W'(DESELECT_CLOCKS);
            end
            OP_INIT: begin
              state_d = INIT;
              csn_d   = '1;
              cnt_d   = CNT_W'(INIT_CLOCKS);
            end
            OP_SETDIV: begin
              state_d = SETDIV;
              shreg_d = wdata;
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      INIT, WRITE, READ, DESELECT: begin
        if (cnt_q == '0) begin
          if (state_q == WRITE) begin
            state_d = READ;
            shreg_d = '1;
            cnt_d   = CNT_W'(rd_len_q);
          end else begin
            state_d = DONE;
            rdata_d = (state_q == READ) ? '0 : rdata_q;
          end
        end else if (tick_s) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            sclk_d = ~CPOL;
            mosi_d = shreg_q[DATA_W-1];
          end else begin
            sclk_d  = CPOL;
            cnt_d   = cnt_q - CNT_W'(1);
            shreg_d = (state_q == WRITE || state_q == READ) ? shift_s : shreg_q;
            if (cnt_q == CNT_W'(1)) begin
              if (state_q == WRITE) begin
                state_d = READ;
                shreg_d = '1;
                cnt_d   = CNT_W'(rd_len_q);
              end else begin
                state_d = DONE;
                rdata_d = (state_q == READ) ? (shift_s & mask_s) : rdata_q;
              end
            end else begin
              state_d = state_q;
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      SETDIV: begin
        div_d   = shreg_q[DIV_W-1:0];
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // MOSI parks high between operations so the next read phase never drives a stale 0.
    if (state_d == DONE && state_q != DONE) begin
      busy_d  = 1'b0;
      ready_d = 1'b1;
      mosi_d  = 1'b1;
    end else begin
      ready_d = ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      shreg_q  <= '1;
      rd_len_q <= '0;
      csn_q    <= '1;
      sclk_q   <= CPOL;
      mosi_q   <= 1'b1;
      rdata_q  <= '0;
      div_q    <= DIV_W'(DIV_RESET);
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      rd_len_q <= rd_len_d;
      csn_q    <= csn_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      rdata_q  <= rdata_d;
      div_q    <= div_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign rdata    = rdata_q;
  assign spi_csn  = csn_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_mmc_master.sv
// Directed bench for spi_mmc_master with a mode-3 card model that logs MOSI on
// rising SCLK and shifts MISO out on falling SCLK.
module tb_spi_mmc_master;
  import spi_mmc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [1:0]  op;
  logic [31:0] wdata;
  logic [5:0]  wr_bits;
  logic [5:0]  rd_bits;
  logic [0:0]  cs_sel;
  logic        ready;
  logic        busy;
  logic [31:0] rdata;
  logic [7:0]  div_q;
  logic [1:0]  spi_csn;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;

  int checks = 0;
  int errors = 0;

  spi_mmc_master dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .wdata(wdata),
    .wr_bits(wr_bits), .rd_bits(rd_bits), .cs_sel(cs_sel), .ready(ready),
    .busy(busy), .rdata(rdata), .div_q(div_q), .spi_csn(spi_csn),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  // Card model: stream card_tx MSB first, one bit per falling SCLK since fall_base.
  logic [63:0] card_tx = 64'h0;
  logic [63:0] mosi_log = 64'h0;
  int  fall_base = 0;
  int  fall_cnt = 0;
  int  rise_cnt = 0;
  int  miso_idx;
  time t_fall = 0;
  time half_t = 0;

  always @(negedge spi_sclk) begin
    fall_cnt <= fall_cnt + 1;
    t_fall   <= $time;
  end

  always @(posedge spi_sclk) begin
    rise_cnt <= rise_cnt + 1;
    mosi_log <= {mosi_log[62:0], spi_mosi};
    half_t   <= $time - t_fall;
  end

  assign miso_idx = fall_cnt - fall_base;
  assign spi_miso = (miso_idx <= 0 || miso_idx > 64) ? 1'b1 : card_tx[6'(64 - miso_idx)];

  task automatic run_op(input logic [1:0] o, input logic [31:0] wd, input logic [5:0] wb,
                        input logic [5:0] rb, input logic cs, input int max_cycles,
                        output int cycles, output int pulses, output logic mosi_and,
                        output logic [1:0] cs_low);
    @(negedge clk);
    valid = 1'b1; op = o; wdata = wd; wr_bits = wb; rd_bits = rb; cs_sel = cs;
    cycles = 0; pulses = 0; mosi_and = 1'b1; cs_low = 2'b00;
    while (pulses == 0 && cycles < max_cycles) begin
      @(negedge clk);
      cycles++;
      mosi_and = mosi_and & spi_mosi;
      cs_low   = cs_low | ~spi_csn;
      if (ready) begin
        pulses++;
        valid = 1'b0;
      end
    end
    valid = 1'b0;
    @(negedge clk);
    if (ready) pulses++;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = 1'b0; op = 2'd0; wdata = 32'h0; wr_bits = 6'd0; rd_bits = 6'd0; cs_sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %0h want 0", rdata); end
    checks++; if (div_q !== 8'd100) begin errors++; $display("FAIL reset_div got %0d want 100", div_q); end
    checks++; if (spi_csn !== 2'b11) begin errors++; $display("FAIL reset_csn got %b want 11", spi_csn); end
    checks++; if (spi_sclk !== 1'b1 || spi_mosi !== 1'b1) begin
      errors++; $display("FAIL reset_pins got sclk=%b mosi=%b want 1 1", spi_sclk, spi_mosi);
    end
    reset = 1'b0;
  endtask

  task automatic test_init();
    int cyc, pul, r0;
    logic ma;
    logic [1:0] csl;
    r0 = rise_cnt;
    run_op(OP_INIT, 32'h0, 6'd0, 6'd0, 1'b0, 17000, cyc, pul, ma, csl);
    checks++; if (pul !== 1) begin errors++; $display("FAIL init_ready_pulses got %0d want 1", pul); end
    checks++; if (cyc !== 16161) begin errors++; $display("FAIL init_latency got %0d want 16161", cyc); end
    checks++; if (rise_cnt - r0 !== 80) begin errors++; $display("FAIL init_clocks got %0d want 80", rise_cnt - r0); end
    checks++; if (half_t !== 1010) begin errors++; $display("FAIL init_half_period got %0t want 1010", half_t); end
    checks++; if (ma !== 1'b1 || mosi_log !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL init_mosi got and=%b log=%h want 1 all-ones", ma, mosi_log);
    end
    checks++; if (csl !== 2'b00 || spi_csn !== 2'b11) begin
      errors++; $display("FAIL init_csn got low_seen=%b csn=%b want 00 11", csl, spi_csn);
    end
    checks++; if (spi_sclk !== 1'b1) begin errors++; $display("FAIL init_sclk_idle got %b want 1", spi_sclk); end
  endtask

  task automatic test_setdiv_write();
    int cyc, pul, r0;
    logic ma;
    logic [1:0] csl;
    run_op(OP_SETDIV, 32'h0000_0003, 6'd0, 6'd0, 1'b0, 50, cyc, pul, ma, csl);
    checks++; if (div_q !== 8'd3) begin errors++; $display("FAIL setdiv_value got %0d want 3", div_q); end
    checks++; if (cyc !== 2 || pul !== 1) begin errors++; $display("FAIL setdiv_timing got cyc=%0d pulses=%0d want 2 1", cyc, pul); end
    r0 = rise_cnt;
    run_op(OP_XFER, 32'h40AB_CDEF, 6'd8, 6'd0, 1'b0, 200, cyc, pul, ma, csl);
    checks++; if (cyc !== 66 || pul !== 1) begin errors++; $display("FAIL write8_timing got cyc=%0d pulses=%0d want 66 1", cyc, pul); end
    checks++; if (rise_cnt - r0 !== 8) begin errors++; $display("FAIL write8_clocks got %0d want 8", rise_cnt - r0); end
    checks++; if (mosi_log[7:0] !== 8'h40) begin errors++; $display("FAIL write8_mosi got %h want 40", mosi_log[7:0]); end
    checks++; if (half_t !== 40) begin errors++; $display("FAIL write8_half_period got %0t want 40", half_t); end
    checks++; if (csl !== 2'b01 || spi_csn !== 2'b10) begin
      errors++; $display("FAIL write8_csn got low_seen=%b csn=%b want 01 10", csl, spi_csn);
    end
  endtask

  task automatic test_read();
    int cyc, pul, r0;
    logic ma;
    logic [1:0] csl;
    card_tx = {8'hA5, 56'h0};
    fall_base = fall_cnt;
    r0 = rise_cnt;
    run_op(OP_XFER, 32'h0, 6'd0, 6'd8, 1'b0, 200, cyc, pul, ma, csl);
    checks++; if (rdata !== 32'h0000_00A5) begin errors++; $display("FAIL read8_rdata got %h want 000000a5", rdata); end
    checks++; if (ma !== 1'b1) begin errors++; $display("FAIL read8_mosi_high got %b want 1", ma); end
    checks++; if (cyc !== 66 || rise_cnt - r0 !== 8) begin
      errors++; $display("FAIL read8_timing got cyc=%0d clocks=%0d want 66 8", cyc, rise_cnt - r0);
    end
  endtask

  task automatic test_full_xfer();
    int cyc, pul, r0;
    logic ma;
    logic [1:0] csl;
    card_tx = {32'h0, 32'h1234_5678};
    fall_base = fall_cnt;
    r0 = rise_cnt;
    run_op(OP_XFER, 32'hDEAD_BEEF, 6'd32, 6'd32, 1'b0, 1000, cyc, pul, ma, csl);
    checks++; if (pul !== 1) begin errors++; $display("FAIL full_ready_pulses got %0d want 1", pul); end
    checks++; if (cyc !== 513) begin errors++; $display("FAIL full_latency got %0d want 513", cyc); end
    checks++; if (rise_cnt - r0 !== 64) begin errors++; $display("FAIL full_clocks got %0d want 64", rise_cnt - r0); end
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL full_rdata got %h want 12345678", rdata); end
    checks++; if (mosi_log !== {32'hDEAD_BEEF, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL full_mosi got %h want deadbeefffffffff", mosi_log);
    end
  endtask

  task automatic test_zero_len();
    int cyc, pul, r0;
    logic ma;
    logic [1:0] csl;
    r0 = rise_cnt;
    run_op(OP_XFER, 32'h0, 6'd0, 6'd0, 1'b0, 50, cyc, pul, ma, csl);
    checks++; if (cyc !== 3 || pul !== 1) begin errors++; $display("FAIL zero_timing got cyc=%0d pulses=%0d want 3 1", cyc, pul); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL zero_rdata got %h want 0", rdata); end
    checks++; if (rise_cnt - r0 !== 0 || spi_csn !== 2'b10) begin
      errors++; $display("FAIL zero_pins got clocks=%0d csn=%b want 0 10", rise_cnt - r0, spi_csn);
    end
  endtask

  task automatic test_valid_drop_and_reset();
    int cyc, pul;
    logic busy_at_ready;
    @(negedge clk);
    valid = 1'b1; op = OP_XFER; wdata = 32'hA500_0000; wr_bits = 6'd8; rd_bits = 6'd0; cs_sel = 1'b0;
    repeat (10) @(negedge clk);
    valid = 1'b0;
    cyc = 0; pul = 0; busy_at_ready = 1'b1;
    while (pul == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ready) begin pul++; busy_at_ready = busy; end
    end
    checks++; if (pul !== 1) begin errors++; $display("FAIL drop_valid_ready got %0d want 1", pul); end
    checks++; if (busy_at_ready !== 1'b0) begin errors++; $display("FAIL drop_valid_busy got %b want 0", busy_at_ready); end
    @(negedge clk);
    valid = 1'b1; op = OP_XFER; wdata = 32'h1234_5678; wr_bits = 6'd32; rd_bits = 6'd32;
    @(negedge clk);
    valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b1 || spi_sclk !== 1'b0) begin
      errors++; $display("FAIL midxfer_state got busy=%b sclk=%b want 1 0", busy, spi_sclk);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (spi_csn !== 2'b11 || spi_sclk !== 1'b1) begin
      errors++; $display("FAIL abort_pins got csn=%b sclk=%b want 11 1", spi_csn, spi_sclk);
    end
    checks++; if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL abort_status got busy=%b ready=%b want 0 0", busy, ready);
    end
    checks++; if (div_q !== 8'd100) begin errors++; $display("FAIL abort_div got %0d want 100", div_q); end
    reset = 1'b0;
    pul = 0;
    repeat (20) begin
      @(negedge clk);
      if (ready) pul++;
    end
    checks++; if (pul !== 0) begin errors++; $display("FAIL abort_no_ready got %0d want 0", pul); end
  endtask

  task automatic test_cs_switch_deselect();
    int cyc, pul, r0;
    logic ma;
    logic [1:0] csl;
    run_op(OP_SETDIV, 32'hFFFF_FF00, 6'd0, 6'd0, 1'b0, 50, cyc, pul, ma, csl);
    checks++; if (div_q !== 8'd0) begin errors++; $display("FAIL setdiv0_value got %0d want 0", div_q); end
    run_op(OP_XFER, 32'hFF00_0000, 6'd8, 6'd0, 1'b0, 100, cyc, pul, ma, csl);
    checks++; if (spi_csn !== 2'b10) begin errors++; $display("FAIL cs0_select got %b want 10", spi_csn); end
    run_op(OP_XFER, 32'h5500_0000, 6'd8, 6'd0, 1'b1, 100, cyc, pul, ma, csl);
    checks++; if (csl !== 2'b10 || spi_csn !== 2'b01) begin
      errors++; $display("FAIL cs1_switch got low_seen=%b csn=%b want 10 01", csl, spi_csn);
    end
    checks++; if (half_t !== 10 || mosi_log[7:0] !== 8'h55) begin
      errors++; $display("FAIL cs1_div0 got half=%0t mosi=%h want 10 55", half_t, mosi_log[7:0]);
    end
    r0 = rise_cnt;
    run_op(OP_DESELECT, 32'h0, 6'd0, 6'd0, 1'b0, 100, cyc, pul, ma, csl);
    checks++; if (csl !== 2'b00 || spi_csn !== 2'b11) begin
      errors++; $display("FAIL deselect_csn got low_seen=%b csn=%b want 00 11", csl, spi_csn);
    end
    checks++; if (rise_cnt - r0 !== 8 || ma !== 1'b1) begin
      errors++; $display("FAIL deselect_clocks got clocks=%0d mosi_and=%b want 8 1", rise_cnt - r0, ma);
    end
    checks++; if (cyc !== 17 || pul !== 1) begin
      errors++; $display("FAIL deselect_timing got cyc=%0d pulses=%0d want 17 1", cyc, pul);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_setdiv_write();
    test_read();
    test_full_xfer();
    test_zero_len();
    test_valid_drop_and_reset();
    test_cs_switch_deselect();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mmc_master.md
Name: spi_mmc_master

Overview:
- Parametrised successor to the single-CS SPI MMC interface.
- A CPU-side request port issues operation codes: INIT clocking, combined write/read transfer, deselect with trailing clocks, and runtime clock-divider programming.
- Supports NUM_CS chip selects, transfer width DATA_W, and a programmable SCLK idle polarity.
- Sits between the SoC memory-mapped bus glue and the SD/MMC card pins.

Parameters:
- DATA_W, 32: shift register width; maximum write and read bits per transfer.
- NUM_CS, 2: number of active-low chip selects.
- DIV_W, 8: clock-divider register width.
- DIV_RESET, 100: divider value after reset (slow init clock).
- INIT_CLOCKS, 80: SCLK cycles issued by INIT with all CS deasserted.
- CPOL, 1: SCLK idle level. CPHA is fixed: MOSI changes on the leading edge, MISO is sampled on the trailing edge.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- valid  in  1  request present; held until ready.
- op  in  2  0=XFER, 1=DESELECT, 2=INIT, 3=SETDIV.
- wdata  in  DATA_W  write data, MSB first; SETDIV uses wdata[DIV_W-1:0].
- wr_bits  in  $clog2(DATA_W+1)  bits to write (XFER).
- rd_bits  in  $clog2(DATA_W+1)  bits to read (XFER).
- cs_sel  in  $clog2(NUM_CS) (min 1)  target chip select (XFER).
- ready  out  1  one-cycle completion pulse.
- busy  out  1  operation in progress.
- rdata  out  DATA_W  captured read bits, right-aligned, zero-extended.
- div_q  out  DIV_W  current divider value.
- spi_csn  out  NUM_CS  active-low chip selects.
- spi_sclk  out  1  SPI clock.
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in.

Behaviour:
- Reset values:
  - ready=0, busy=0, rdata=0.
  - div_q=DIV_RESET.
  - spi_csn=all 1, spi_sclk=CPOL, spi_mosi=1.
  - state=IDLE, clkcnt=0, bit counter=0.
- Reset mid-operation: all of the above takes effect on the next edge. No ready pulse is issued for the aborted operation.
- Tick generation: clkcnt runs 0..div_q and a tick fires when clkcnt==div_q. One SCLK half-period is div_q+1 clk cycles. clkcnt is held at 0 in IDLE.
- Each SCLK cycle is two ticks:
  - Leading tick: sclk <= ~CPOL, mosi <= shreg[DATA_W-1].
  - Trailing tick: sclk <= CPOL, shreg <= {shreg[DATA_W-2:0], miso}, bit counter decrements.
- Accept: in IDLE with valid=1, the request is latched and busy=1 from the next cycle. valid deassertion after accept is ignored; the operation always completes.
- ready is pulsed exactly one cycle on the transition to IDLE, and busy falls in that same cycle. A new request may be accepted in the cycle after ready.
- States and transitions:
  - IDLE: dispatch on op.
  - INIT: spi_csn=all 1, shreg=all 1, INIT_CLOCKS SCLK cycles, then DONE.
  - WRITE:
    - Entry: shreg=wdata, csn[cs_sel]=0, count=min(wr_bits,DATA_W).
    - Count reaches 0: go to READ.
    - Entry with count 0: go to READ next cycle.
  - READ:
    - Entry: shreg=all 1 (MOSI stays high), count=min(rd_bits,DATA_W).
    - Count reaches 0: rdata <= shreg masked to the low rd_bits bits, then DONE.
  - DESELECT: spi_csn=all 1, then 8 SCLK cycles with mosi=1 (MMC trailing clocks), then DONE.
  - SETDIV: div_q <= wdata[DIV_W-1:0], then DONE. No SCLK activity.
  - DONE: ready=1, go to IDLE.
- XFER leaves CS asserted. Only DESELECT or INIT deasserts it.
- Selecting a new cs_sel while another CS is asserted deasserts the old CS at WRITE entry; at most one CS is low at any time.
- Edge cases:
  - XFER with wr_bits=0 and rd_bits=0: CS asserted, no clocks, ready 3 cycles after accept, rdata=0.
  - cs_sel >= NUM_CS: treated as DESELECT.
  - SETDIV with value 0: tick every cycle, SCLK = clk/2.
  - A new div_q applies from the next operation.

Decomposition:
- Package spi_mmc_pkg holds:
  - op enum: OP_XFER, OP_DESELECT, OP_INIT, OP_SETDIV.
  - state enum: IDLE, INIT, WRITE, READ, DESELECT, SETDIV, DONE.
  - constant DESELECT_CLOCKS=8.
- One sub-module, spi_clk_tick: divider counter with enable and div input, producing a tick pulse.

Test Plan:
1. Reset, then INIT (DIV_RESET=100). Expect spi_csn=2'b11 and exactly 80 SCLK cycles with mosi=1. Each half-period is 101 clks. Expect one ready pulse, then sclk=1.
2. SETDIV wdata=3, then XFER wr_bits=8 rd_bits=0 wdata=0x40xxxxxx, cs_sel=0. Expect csn=2'b10, MOSI bits 01000000 on leading edges, half-period 4 clks, ready, and CS still low afterwards.
3. XFER wr_bits=0 rd_bits=8 with the card model driving 0xA5. Expect rdata=0x000000A5 and mosi held at 1 throughout.
4. XFER wr_bits=32 rd_bits=32, wdata=0xDEADBEEF, model returns 0x12345678. Expect 64 SCLK cycles, rdata=0x12345678, and a single ready pulse.
5. Drop valid mid-transfer. The operation still completes with ready. Then assert reset mid-transfer: next cycle csn=all 1, sclk=1, busy=0, and no ready pulse.
6. XFER cs_sel=1 while CS0 is low, then DESELECT. Expect CS0 to rise at WRITE entry and only CS1 to go low. After DESELECT, expect 8 clocks with all CS high, then ready.
